// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: rising-edge key detect, IDLE/RUN/PAUSE state machine,
// centisecond prescaler and an MM:SS.cc BCD time counter with rollover pulse.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000,
  parameter int PRE_W    = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_start,
  input  logic        key_clear,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic        wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [23:0]      TIME_LAST = 24'h595999;

  state_t           state, state_nxt;
  logic             start_prev, clear_prev;
  logic             start_edge, clear_edge;
  logic [PRE_W-1:0] pre_cnt, pre_nxt;
  logic [23:0]      time_q, time_nxt;
  logic             tick, time_clr, wrap_nxt;

  // Digits from c_lo upward; the tens-of-seconds and tens-of-minutes digits stop at 5.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  dmax;
    r     = t;
    carry = 1'b1;
    for (int d = 0; d < 6; d++) begin
      dmax = ((d == 3) || (d == 5)) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[d*4 +: 4] >= dmax) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign start_edge = key_start & ~start_prev;
  assign clear_edge = key_clear & ~clear_prev;

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre_cnt;
    time_clr  = 1'b0;
    tick      = (state == RUN) && (pre_cnt == PRE_LAST);
    if (state == RUN) begin
      pre_nxt = tick ? '0 : pre_cnt + 1'b1;
    end
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = RUN;
          pre_nxt   = '0;
        end
        if (clear_edge) time_clr = 1'b1;
      end
      RUN: begin
        if (start_edge) state_nxt = PAUSE;
      end
      PAUSE: begin
        // Clear wins over a start edge arriving on the same cycle.
        if (clear_edge) begin
          state_nxt = IDLE;
          pre_nxt   = '0;
          time_clr  = 1'b1;
        end else if (start_edge) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        pre_nxt   = '0;
        time_clr  = 1'b1;
      end
    endcase
    time_nxt = time_clr ? '0 : (tick ? bcd_inc(time_q) : time_q);
    wrap_nxt = tick && (time_q == TIME_LAST);
  end

  // Key history resets high so a key held through reset release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      start_prev <= 1'b1;
      clear_prev <= 1'b1;
      pre_cnt    <= '0;
      time_q     <= '0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_prev <= key_start;
      clear_prev <= key_clear;
      pre_cnt    <= pre_nxt;
      time_q     <= time_nxt;
      wrap       <= wrap_nxt;
    end
  end

  assign time_bcd = time_q;
  assign running  = (state == RUN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: an integer-centisecond reference model
// queues the expected outputs per clock; a monitor pops and compares them.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int PRE_W    = 3;
  localparam int FULL_CS  = 360000;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_start;
  logic        key_clear;
  logic [23:0] time_bcd;
  logic        running;
  logic        wrap;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .PRE_W(PRE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_start (key_start),
    .key_clear (key_clear),
    .time_bcd  (time_bcd),
    .running   (running),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] t;
    logic        r;
    logic        w;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] force_val;
  bit          forced = 0;

  // Reference model: mode 0 = idle, 1 = run, 2 = pause; time kept as centiseconds.
  int m_mode, m_cs, m_phase;
  bit m_sp, m_cp;

  function automatic logic [23:0] to_bcd(input int cs);
    int mm, ss, cc;
    mm = cs / 6000;
    ss = (cs / 100) % 60;
    cc = cs % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cs = 0; m_phase = 0; m_sp = 1; m_cp = 1;
  endtask

  task automatic model_step(input bit ks, input bit kc, output exp_t e);
    bit se, ce, tk, wr;
    se = ks && !m_sp;
    ce = kc && !m_cp;
    m_sp = ks;
    m_cp = kc;
    tk = (m_mode == 1) && (m_phase == TICK_DIV - 1);
    wr = 0;
    if (m_mode == 1) m_phase = tk ? 0 : m_phase + 1;
    if (tk) begin
      m_cs = m_cs + 1;
      if (m_cs == FULL_CS) begin
        m_cs = 0;
        wr = 1;
      end
    end
    case (m_mode)
      0: begin
        if (se) begin m_mode = 1; m_phase = 0; end
        else if (ce) m_cs = 0;
      end
      1: if (se) m_mode = 2;
      default: begin
        if (ce) begin m_mode = 0; m_cs = 0; m_phase = 0; end
        else if (se) m_mode = 1;
      end
    endcase
    e.t = to_bcd(m_cs);
    e.r = (m_mode == 1);
    e.w = wr;
  endtask

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are compared 1 time unit after every edge that has an expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("time_bcd", time_bcd, e.t);
        check("running", 24'(running), 24'(e.r));
        check("wrap", 24'(wrap), 24'(e.w));
      end
    end
  end

  task automatic step(input bit ks, input bit kc, input bit rn);
    exp_t e;
    @(posedge clk);
    #2;
    if (forced) begin
      release dut.time_q;
      forced = 0;
    end
    key_start = ks;
    key_clear = kc;
    reset     = rn;
    if (!rn) begin
      model_reset();
      e = '0;
    end else begin
      model_step(ks, kc, e);
    end
    exp_q.push_back(e);
  endtask

  // Only used while paused, where the time register simply holds.
  task step_force(input int cs);
    exp_t e;
    @(posedge clk);
    #2;
    force_val = to_bcd(cs);
    force dut.time_q = force_val;
    forced = 1;
    m_cs = cs;
    model_step(key_start, key_clear, e);
    exp_q.push_back(e);
  endtask

  task automatic press_start();
    step(0, 0, 1);
    step(1, 0, 1);
    step(0, 0, 1);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    check("async_time", time_bcd, 24'h0);
    check("async_running", 24'(running), 24'h0);
    check("async_wrap", 24'(wrap), 24'h0);
    model_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ks, kc;
    reset = 0; key_start = 1; key_clear = 0;
    model_reset();
    // Key held through reset release produces no edge.
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 1);
    step(0, 0, 1);
    step(1, 0, 1);
    for (int i = 0; i < 40; i++) step(1, 0, 1);
    // Pause, frozen value, then simultaneous start+clear returns to idle.
    press_start();
    run_cycles(100);
    step(1, 1, 1);
    step(0, 0, 1);
    press_start();
    run_cycles(8);
    // Carry 00:00.99 -> 00:01.00
    press_start();
    step_force(99 - 1);
    press_start();
    run_cycles(12);
    // Carry 09:59.99 -> 10:00.00
    press_start();
    step_force(9 * 6000 + 5999 - 1);
    press_start();
    run_cycles(12);
    // Full rollover, with a clear press in RUN that must be ignored.
    press_start();
    step_force(FULL_CS - 2);
    press_start();
    step(0, 1, 1);
    step(0, 0, 1);
    run_cycles(10);
    // Pause mid-prescale and resume.
    step(1, 0, 1);
    step(0, 0, 1);
    step(1, 0, 1);
    run_cycles(3);
    press_start();
    run_cycles(6);
    async_reset();
    // Randomized key activity.
    ks = 0; kc = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) ks = !ks;
      if ($urandom_range(0, 15) == 0) kc = !kc;
      step(ks, kc, 1);
      if (i == 1500 && m_cs != 0) async_reset();
    end
    @(posedge clk);
    #3;
    check("queue_drained", 24'(exp_q.size()), 24'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
